mfp_ahb_gpio_irq: RTL
=====================

Name: mfp_ahb_gpio_irq

Overview:
- Parametrised AHB-Lite GPIO slave for the MFP system; successor to the fixed switch/PB/LED GPIO port.
- Generic input bank with multi-stage synchroniser, per-bit rising/falling edge detection and sticky interrupt status.
- Generic output bank with atomic set/clear write aliases and a single level interrupt to the core.
- Zero-wait-state slave on the AHB-Lite bus; decoded by the existing bus mux via HSEL.

Parameters:
- N_IN, 16, number of input pins (1..32).
- N_OUT, 16, number of output pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (>=2).

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  reset
- HADDR  in  6  byte address; register index = HADDR[5:2]
- HTRANS  in  2  AHB transfer type
- HWDATA  in  32  write data (data phase)
- HWRITE  in  1  write strobe (address phase)
- HSEL  in  1  slave select
- HRDATA  out  32  read data
- GPIO_IN  in  N_IN  asynchronous input pins
- GPIO_OUT  out  N_OUT  output pins
- IRQ  out  1  level interrupt, active-high

Behaviour:
- Reset: HRESETn, asynchronous, active-low; clock HCLK. All registers, sync stages, edge history, HRDATA, GPIO_OUT and IRQ reset to 0.
- Register map (index: name, access):
  - 0 DATA_IN, RO: synchronised inputs.
  - 1 DATA_OUT, RW.
  - 2 OUT_SET, WO: write-1-sets DATA_OUT bits.
  - 3 OUT_CLR, WO: write-1-clears DATA_OUT bits.
  - 4 IRQ_EN, RW.
  - 5 EDGE_RISE, RW.
  - 6 EDGE_FALL, RW.
  - 7 IRQ_STATUS, RW1C.
  - 8..15: read 0, writes ignored.
- Address/control phase (HADDR[5:2], HWRITE, HSEL, HTRANS) is registered each cycle.
- Write enable: we = HSEL_d & HWRITE_d & (HTRANS_d != IDLE). Register updates with HWDATA at the end of the data phase; the new value is visible the cycle after.
- Read: HRDATA registered from the address-phase index every cycle, valid in the data phase (1-cycle latency, zero wait). Unused upper bits read 0. WO registers read 0.
- Read-after-write back-to-back to the same register returns the pre-write value. Single write port, so no set/clear conflict.
- Input path:
  - SYNC_STAGES flops feed s = synced input; prev = s delayed one cycle.
  - rise = s & ~prev; fall = ~s & prev.
  - ev = (rise & EDGE_RISE) | (fall & EDGE_FALL).
- Status update each cycle: STATUS <= (STATUS & ~w1c) | ev, where w1c = HWDATA masked when writing index 7, else 0.
  - Event sets status regardless of IRQ_EN.
  - Simultaneous event and W1C on the same bit: set wins.
- First cycle after reset: prev = 0, so a pin already high at reset produces a rise event once synced if EDGE_RISE is set. No event is possible while EDGE_* = 0 (reset default).
- IRQ registered: IRQ <= |(STATUS & IRQ_EN). Deasserts one cycle after the status bit is cleared or its enable is cleared.
- Latency from GPIO_IN pin change to IRQ: SYNC_STAGES + 2 cycles.
- Reset mid-transfer: the pending write is discarded; the bus master must restart.

Decomposition:
- mfp_ahb_const.vh gains: register index constants (H_GPIO_DATAIN .. H_GPIO_IRQSTAT), GPIO address width, and the existing HTRANS_IDLE.
- Sub-module mfp_gpio_edge_detect, parametrised WIDTH and SYNC_STAGES: synchroniser, prev register, rise/fall outputs. Instantiated once with N_IN.

Test Plan:
- Reset then read all 8 indices: all return 0x00000000, GPIO_OUT=0, IRQ=0.
- Write DATA_OUT=0x00F0, OUT_SET=0x0003, OUT_CLR=0x0010: GPIO_OUT=0x00E3, DATA_OUT reads 0x000000E3.
- EDGE_RISE=0x1, IRQ_EN=0x1; drive GPIO_IN[0] 0->1: STATUS=0x1 and IRQ=1 exactly SYNC_STAGES+2 cycles after the pin change. Write 0x1 to IRQ_STATUS: IRQ=0 next cycle.
- EDGE_FALL=0x4, IRQ_EN=0: falling edge on bit 2 gives STATUS=0x4 and IRQ stays 0. Then set IRQ_EN=0x4: IRQ=1.
- Time the rise edge on bit 0 so the event lands in the same cycle as a W1C of bit 0: STATUS bit 0 remains 1.
- Assert HRESETn low mid data phase of a DATA_OUT write of 0xFFFF: GPIO_OUT=0 after reset, write not applied.

Source files
------------

// File: rtl/mfp_ahb_gpio_irq_pkg.sv
// Shared constants for the MFP AHB-Lite GPIO/IRQ slave.
//   GPIO_ADDR_WIDTH : width of the HADDR slice routed to the GPIO slave
//   HTRANS_IDLE     : AHB-Lite IDLE transfer encoding
//   gpio_reg_e      : register indices, decoded from HADDR[5:2]
package mfp_ahb_gpio_irq_pkg;

  localparam int unsigned GPIO_ADDR_WIDTH = 6;
  localparam logic [1:0]  HTRANS_IDLE     = 2'b00;

  typedef enum logic [3:0] {
    H_GPIO_DATAIN   = 4'd0,
    H_GPIO_DATAOUT  = 4'd1,
    H_GPIO_OUTSET   = 4'd2,
    H_GPIO_OUTCLR   = 4'd3,
    H_GPIO_IRQEN    = 4'd4,
    H_GPIO_EDGERISE = 4'd5,
    H_GPIO_EDGEFALL = 4'd6,
    H_GPIO_IRQSTAT  = 4'd7
  } gpio_reg_e;

endpackage

// File: rtl/mfp_gpio_edge_detect.sv
// Input synchroniser with per-bit rising/falling edge detection.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : asynchronous input pins
//   sync       : synchronised inputs (last synchroniser stage)
//   rise, fall : single-cycle edge pulses of sync versus its previous value
module mfp_gpio_edge_detect #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Element 0 is the first stage; element SYNC_STAGES-1 is the synced value.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/mfp_ahb_gpio_irq.sv
// Zero-wait-state AHB-Lite GPIO slave with edge-triggered sticky interrupts.
//   HCLK, HRESETn : bus clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE/HSEL : address/control phase, registered every cycle
//   HWDATA        : write data (data phase)
//   HRDATA        : registered read data, valid in the data phase
//   GPIO_IN       : asynchronous input pins
//   GPIO_OUT      : output pins (DATA_OUT register)
//   IRQ           : registered level interrupt, |(IRQ_STATUS & IRQ_EN)
module mfp_ahb_gpio_irq
  import mfp_ahb_gpio_irq_pkg::*;
#(
  parameter int unsigned N_IN        = 16,
  parameter int unsigned N_OUT       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [GPIO_ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]                 HTRANS,
  input  logic [31:0]                HWDATA,
  input  logic                       HWRITE,
  input  logic                       HSEL,
  output logic [31:0]                HRDATA,
  input  logic [N_IN-1:0]            GPIO_IN,
  output logic [N_OUT-1:0]           GPIO_OUT,
  output logic                       IRQ
);

  logic [3:0]       addr_q, addr_d;
  logic             write_q, write_d;
  logic             sel_q, sel_d;
  logic [1:0]       trans_q, trans_d;
  logic [N_OUT-1:0] data_out_q, data_out_d;
  logic [N_IN-1:0]  irq_en_q, irq_en_d;
  logic [N_IN-1:0]  rise_en_q, rise_en_d;
  logic [N_IN-1:0]  fall_en_q, fall_en_d;
  logic [N_IN-1:0]  status_q, status_d;
  logic [31:0]      hrdata_q, hrdata_d;
  logic             irq_q, irq_d;

  logic             we;
  logic [N_IN-1:0]  w1c, ev, sync_in, rise, fall;

  // HWDATA bits above the register widths and the byte-lane address bits
  // are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{HWDATA, HADDR[1:0]};

  mfp_gpio_edge_detect #(
    .WIDTH       (N_IN),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .din   (GPIO_IN),
    .sync  (sync_in),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    addr_d     = HADDR[5:2];
    write_d    = HWRITE;
    sel_d      = HSEL;
    trans_d    = HTRANS;
    data_out_d = data_out_q;
    irq_en_d   = irq_en_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c        = '0;

    we = sel_q & write_q & (trans_q != HTRANS_IDLE);
    if (we) begin
      case (addr_q)
        H_GPIO_DATAOUT:  data_out_d = HWDATA[N_OUT-1:0];
        H_GPIO_OUTSET:   data_out_d = data_out_q | HWDATA[N_OUT-1:0];
        H_GPIO_OUTCLR:   data_out_d = data_out_q & ~HWDATA[N_OUT-1:0];
        H_GPIO_IRQEN:    irq_en_d   = HWDATA[N_IN-1:0];
        H_GPIO_EDGERISE: rise_en_d  = HWDATA[N_IN-1:0];
        H_GPIO_EDGEFALL: fall_en_d  = HWDATA[N_IN-1:0];
        H_GPIO_IRQSTAT:  w1c        = HWDATA[N_IN-1:0];
        default: ;
      endcase
    end

    // Event is OR'd in after the clear, so a same-cycle event wins over W1C.
    ev       = (rise & rise_en_q) | (fall & fall_en_q);
    status_d = (status_q & ~w1c) | ev;
    irq_d    = |(status_q & irq_en_q);

    // Read mux uses the live address phase so data lands in the data phase;
    // a write in the same cycle is not yet visible (pre-write value).
    case (HADDR[5:2])
      H_GPIO_DATAIN:   hrdata_d = 32'(sync_in);
      H_GPIO_DATAOUT:  hrdata_d = 32'(data_out_q);
      H_GPIO_IRQEN:    hrdata_d = 32'(irq_en_q);
      H_GPIO_EDGERISE: hrdata_d = 32'(rise_en_q);
      H_GPIO_EDGEFALL: hrdata_d = 32'(fall_en_q);
      H_GPIO_IRQSTAT:  hrdata_d = 32'(status_q);
      default:         hrdata_d = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q     <= '0;
      write_q    <= 1'b0;
      sel_q      <= 1'b0;
      trans_q    <= '0;
      data_out_q <= '0;
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      hrdata_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      write_q    <= write_d;
      sel_q      <= sel_d;
      trans_q    <= trans_d;
      data_out_q <= data_out_d;
      irq_en_q   <= irq_en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      hrdata_q   <= hrdata_d;
      irq_q      <= irq_d;
    end
  end

  assign HRDATA   = hrdata_q;
  assign GPIO_OUT = data_out_q;
  assign IRQ      = irq_q;

endmodule
